// File: rtl/alu_acc_seq_if.sv
// alu_acc_seq_if: request/result bundle for the accumulator ALU.
//   master (decoder side) drives a, b, ctr, sel_acc, in_valid and
//   observes in_ready, o, flags, out_valid.
//   slave (ALU side) is the mirror image.
//   W: datapath width, must match the ALU instance.
interface alu_acc_seq_if #(
  parameter int W = 8
);
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   ctr;
  logic         sel_acc;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] o;
  logic [3:0]   flags;
  logic         out_valid;

  modport master (
    output a, b, ctr, sel_acc, in_valid,
    input  in_ready, o, flags, out_valid
  );

  modport slave (
    input  a, b, ctr, sel_acc, in_valid,
    output in_ready, o, flags, out_valid
  );
endinterface

// File: rtl/alu_acc_seq.sv
// alu_acc_seq: W-bit accumulator ALU with 4-bit opcode, carry-chained
// add/subtract, variable shifts/rotates and a W-cycle shift-add multiply.
// Ports:
//   ck        clock, all state updates on the rising edge
//   rst_n     asynchronous active-low reset
//   bus       alu_acc_seq_if.slave:
//               a, b, ctr, sel_acc, in_valid  request (sampled on acceptance)
//               in_ready                      high while idle
//               o, flags {C,V,N,Z}, out_valid registered result, one edge
//                                             after the accumulator update
module alu_acc_seq #(
  parameter int W = 8
) (
  input logic          ck,
  input logic          rst_n,
  alu_acc_seq_if.slave bus
);
  localparam int SW = $clog2(W);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_ADC = 4'b0010;
  localparam logic [3:0] OP_SBB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1011;
  localparam logic [3:0] OP_SHR = 4'b1100;
  localparam logic [3:0] OP_SHL = 4'b1101;
  localparam logic [3:0] OP_ROR = 4'b1110;
  localparam logic [3:0] OP_ROL = 4'b1111;

  logic [0:0]     state;
  logic [W-1:0]   acc;
  logic [3:0]     freg;      // {C,V,N,Z} belonging to acc
  logic [W-1:0]   mcand;
  logic [W-1:0]   mplier;
  logic [2*W-1:0] prod;
  logic [SW-1:0]  cnt;
  logic           done;      // acc/freg written on the last edge

  logic [W-1:0]   opa;
  logic [SW-1:0]  s;
  logic [SW-1:0]  neg_s;
  logic           cin;
  logic [W:0]     add_sum;
  logic [W:0]     sub_diff;
  logic [W:0]     shr_ext;
  logic [W:0]     shl_ext;
  logic [W-1:0]   res;
  logic           c_flag;
  logic           v_flag;
  logic [2*W-1:0] addend;
  logic [2*W-1:0] prod_next;
  logic           mul_last;

  // Flag nibble {C,V,N,Z} for a finished result.
  function automatic logic [3:0] pack_flags(input logic c, input logic v,
                                            input logic [W-1:0] r);
    return {c, v, r[W-1], ~|r};
  endfunction

  assign bus.in_ready = (state == IDLE);
  assign opa   = bus.sel_acc ? acc : bus.a;
  assign s     = bus.b[SW-1:0];
  // (W - s) mod W; for s=0 both rotate halves equal opa, so the OR is opa.
  assign neg_s = {SW{1'b0}} - s;

  // Single-cycle result and flags for every non-multiply opcode.
  always_comb begin
    cin      = ((bus.ctr == OP_ADC) || (bus.ctr == OP_SBB)) ? freg[3] : 1'b0;
    add_sum  = {1'b0, opa} + {1'b0, bus.b} + {{W{1'b0}}, cin};
    // Bit W of the difference is the borrow: set when A < b + Cin.
    sub_diff = {1'b0, opa} - {1'b0, bus.b} - {{W{1'b0}}, cin};
    // The guard bit below/above the operand catches the last bit shifted out.
    shr_ext  = {opa, 1'b0} >> s;
    shl_ext  = {1'b0, opa} << s;
    res      = {W{1'b0}};
    c_flag   = 1'b0;
    v_flag   = 1'b0;
    case (bus.ctr)
      OP_ADD, OP_ADC: begin
        res    = add_sum[W-1:0];
        c_flag = add_sum[W];
        v_flag = (opa[W-1] == bus.b[W-1]) && (res[W-1] != opa[W-1]);
      end
      OP_SUB, OP_SBB: begin
        res    = sub_diff[W-1:0];
        c_flag = sub_diff[W];
        v_flag = (opa[W-1] != bus.b[W-1]) && (res[W-1] != opa[W-1]);
      end
      OP_AND: res = opa & bus.b;
      OP_OR:  res = opa | bus.b;
      OP_XOR: res = opa ^ bus.b;
      OP_SHR: begin
        res    = shr_ext[W:1];
        c_flag = shr_ext[0];
      end
      OP_SHL: begin
        res    = shl_ext[W-1:0];
        c_flag = shl_ext[W];
      end
      OP_ROR: begin
        res    = (opa >> s) | (opa << neg_s);
        c_flag = (s != {SW{1'b0}}) ? res[W-1] : 1'b0;
      end
      OP_ROL: begin
        res    = (opa << s) | (opa >> neg_s);
        c_flag = (s != {SW{1'b0}}) ? res[0] : 1'b0;
      end
      default: begin
        res    = {W{1'b0}};
        c_flag = 1'b0;
        v_flag = 1'b0;
      end
    endcase
  end

  // One shift-add multiply step: add multiplicand << cnt when multiplier bit cnt is set.
  always_comb begin
    addend    = {{W{1'b0}}, mcand} << cnt;
    prod_next = mplier[cnt] ? (prod + addend) : prod;
    mul_last  = (cnt == SW'(W - 1));
  end

  // Control FSM, accumulator, flag register and multiplier datapath.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= {W{1'b0}};
      freg   <= 4'b0000;
      mcand  <= {W{1'b0}};
      mplier <= {W{1'b0}};
      prod   <= {(2*W){1'b0}};
      cnt    <= {SW{1'b0}};
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.ctr == OP_MUL) begin
              mcand  <= opa;
              mplier <= bus.b;
              prod   <= {(2*W){1'b0}};
              cnt    <= {SW{1'b0}};
              state  <= MUL;
            end else begin
              acc  <= res;
              freg <= pack_flags(c_flag, v_flag, res);
              done <= 1'b1;
            end
          end
        end
        MUL: begin
          prod <= prod_next;
          cnt  <= cnt + SW'(1);
          if (mul_last) begin
            acc   <= prod_next[W-1:0];
            freg  <= pack_flags(|prod_next[2*W-1:W], 1'b0, prod_next[W-1:0]);
            done  <= 1'b1;
            cnt   <= {SW{1'b0}};
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result port: copy of acc/freg one edge after each completion.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      bus.o         <= {W{1'b0}};
      bus.flags     <= 4'b0000;
      bus.out_valid <= 1'b0;
    end else begin
      if (done) begin
        bus.o     <= acc;
        bus.flags <= freg;
      end
      bus.out_valid <= done;
    end
  end
endmodule

// File: tb/tb_alu_acc_seq.sv
module tb_alu_acc_seq;
  logic ck = 1'b0;
  logic rst_n = 1'b0;
  logic chk_en = 1'b0;
  int total = 0;
  int bad = 0;

  alu_acc_seq_if #(.W(8))  bus8();
  alu_acc_seq_if #(.W(16)) bus16();

  alu_acc_seq #(.W(8))  dut8  (.ck(ck), .rst_n(rst_n), .bus(bus8));
  alu_acc_seq #(.W(16)) dut16 (.ck(ck), .rst_n(rst_n), .bus(bus16));

  always #5 ck = ~ck;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU from the opcode table, in plain 64-bit arithmetic.
  function automatic void ref_op(input logic [3:0] op, input longint unsigned av,
                                 input longint unsigned bv, input logic cin, input int w,
                                 output longint unsigned res, output logic [3:0] fl);
    longint unsigned mask, full, cc;
    longint hs, sa, sb, st;
    int s;
    logic c, v;
    mask = (64'd1 << w) - 64'd1;
    hs   = longint'(64'd1 << (w - 1));
    sa   = (av >= 64'(hs)) ? longint'(av) - 2 * hs : longint'(av);
    sb   = (bv >= 64'(hs)) ? longint'(bv) - 2 * hs : longint'(bv);
    s    = int'(bv & 64'(w - 1));
    cc   = ((op == 4'h2) || (op == 4'h3)) ? 64'(cin) : 64'd0;
    c = 1'b0; v = 1'b0; res = 64'd0;
    case (op)
      4'h0, 4'h2: begin
        full = av + bv + cc;
        res  = full & mask;
        c    = ((full >> w) & 64'd1) != 64'd0;
        st   = sa + sb + longint'(cc);
        v    = (st >= hs) || (st < -hs);
      end
      4'h1, 4'h3: begin
        c   = av < (bv + cc);
        res = (av - bv - cc) & mask;
        st  = sa - sb - longint'(cc);
        v   = (st >= hs) || (st < -hs);
      end
      4'h8: res = av & bv;
      4'h9: res = av | bv;
      4'hA: res = av ^ bv;
      4'hB: begin
        full = av * bv;
        res  = full & mask;
        c    = (full >> w) != 64'd0;
      end
      4'hC: begin
        res = av >> s;
        c   = (s != 0) ? (((av >> (s - 1)) & 64'd1) != 64'd0) : 1'b0;
      end
      4'hD: begin
        res = (av << s) & mask;
        c   = (s != 0) ? (((av >> (w - s)) & 64'd1) != 64'd0) : 1'b0;
      end
      4'hE: begin
        res = ((av >> s) | (av << (w - s))) & mask;
        c   = (s != 0) ? (((res >> (w - 1)) & 64'd1) != 64'd0) : 1'b0;
      end
      4'hF: begin
        res = ((av << s) | (av >> (w - s))) & mask;
        c   = (s != 0) ? ((res & 64'd1) != 64'd0) : 1'b0;
      end
      default: res = 64'd0;
    endcase
    fl = {c, v, ((res >> (w - 1)) & 64'd1) != 64'd0, res == 64'd0};
  endfunction

  // Cycle-level model of the W=8 instance: busy countdown, acc, flag reg, visible outputs.
  longint unsigned m_acc = 0, m_o = 0, pend_res = 0;
  logic [3:0] m_freg = 4'd0, m_fl = 4'd0, pend_fl = 4'd0;
  logic m_ov = 1'b0, m_done = 1'b0;
  int m_busy = 0;

  initial forever begin
    longint unsigned av, r;
    logic [3:0] f;
    @(posedge ck or negedge rst_n);
    if (!rst_n) begin
      m_acc = 0; m_o = 0; m_freg = 4'd0; m_fl = 4'd0;
      m_ov = 1'b0; m_done = 1'b0; m_busy = 0;
    end else begin
      if (m_done) begin
        m_o  = m_acc;
        m_fl = m_freg;
      end
      m_ov   = m_done;
      m_done = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_acc  = pend_res;
          m_freg = pend_fl;
          m_done = 1'b1;
        end
      end else if (bus8.in_valid) begin
        av = bus8.sel_acc ? m_acc : 64'(bus8.a);
        ref_op(bus8.ctr, av, 64'(bus8.b), m_freg[3], 8, r, f);
        if (bus8.ctr == 4'hB) begin
          pend_res = r;
          pend_fl  = f;
          m_busy   = 8;
        end else begin
          m_acc  = r;
          m_freg = f;
          m_done = 1'b1;
        end
      end
    end
  end

  // Compare process: every cycle, on the falling edge.
  initial forever begin
    @(negedge ck);
    if (chk_en) begin
      check("cmp in_ready",  64'(bus8.in_ready),  64'(m_busy == 0));
      check("cmp out_valid", 64'(bus8.out_valid), 64'(m_ov));
      check("cmp o",         64'(bus8.o),         m_o);
      check("cmp flags",     64'(bus8.flags),     64'(m_fl));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one request to the W=8 instance; return just after edge N+1.
  task automatic issue(input logic [3:0] c, input logic [7:0] av, input logic [7:0] bv,
                       input logic sel);
    bus8.ctr = c; bus8.a = av; bus8.b = bv; bus8.sel_acc = sel; bus8.in_valid = 1'b1;
    @(posedge ck); #1;
    bus8.in_valid = 1'b0;
    @(posedge ck); #1;
  endtask

  task automatic expect8(input string name, input logic [7:0] eo, input logic [3:0] ef);
    check({name, " o"},     64'(bus8.o),         64'(eo));
    check({name, " flags"}, 64'(bus8.flags),     64'(ef));
    check({name, " ov"},    64'(bus8.out_valid), 64'd1);
  endtask

  initial begin
    logic [7:0] chain [4];
    longint unsigned r16;
    logic [3:0] f16;
    chain[0] = 8'd1; chain[1] = 8'd3; chain[2] = 8'd6; chain[3] = 8'd10;
    bus8.a = 8'd0; bus8.b = 8'd0; bus8.ctr = 4'd0; bus8.sel_acc = 1'b0; bus8.in_valid = 1'b0;
    bus16.a = 16'd0; bus16.b = 16'd0; bus16.ctr = 4'd0; bus16.sel_acc = 1'b0; bus16.in_valid = 1'b0;
    repeat (3) @(posedge ck);
    @(negedge ck);
    rst_n = 1'b1;
    chk_en = 1'b1;
    check("rst o", 64'(bus8.o), 64'd0);
    check("rst flags", 64'(bus8.flags), 64'd0);
    check("rst ov", 64'(bus8.out_valid), 64'd0);
    check("rst rdy", 64'(bus8.in_ready), 64'd1);
    @(posedge ck); #1;

    issue(4'h0, 8'hF0, 8'h20, 1'b0);  expect8("add", 8'h10, 4'b1000);
    @(posedge ck); #1;
    check("add pulse end", 64'(bus8.out_valid), 64'd0);
    issue(4'h1, 8'h80, 8'h01, 1'b0);  expect8("sub", 8'h7F, 4'b0100);
    issue(4'h3, 8'h00, 8'h7F, 1'b1);  expect8("sbb", 8'h00, 4'b0001);
    issue(4'hF, 8'h81, 8'h03, 1'b0);  expect8("rol", 8'h0C, 4'b0000);
    issue(4'hC, 8'h81, 8'h01, 1'b0);  expect8("shr", 8'h40, 4'b1000);
    issue(4'hD, 8'h81, 8'h00, 1'b0);  expect8("shl0", 8'h81, 4'b0010);

    // MUL with in_valid held high through the busy window.
    bus8.ctr = 4'hB; bus8.a = 8'h12; bus8.b = 8'h10; bus8.sel_acc = 1'b0; bus8.in_valid = 1'b1;
    @(posedge ck); #1;
    bus8.ctr = 4'h0; bus8.a = 8'h01; bus8.b = 8'h01;
    for (int i = 0; i < 8; i++) begin
      check("mul busy", 64'(bus8.in_ready), 64'd0);
      @(posedge ck); #1;
    end
    check("mul ready back", 64'(bus8.in_ready), 64'd1);
    bus8.in_valid = 1'b0;
    @(posedge ck); #1;
    expect8("mul", 8'h20, 4'b1000);

    issue(4'h4, 8'h55, 8'h66, 1'b0);  expect8("undef", 8'h00, 4'b0001);

    // Four chained ADDs from the accumulator on consecutive cycles.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        bus8.ctr = 4'h0; bus8.sel_acc = 1'b1; bus8.b = 8'(i + 1); bus8.in_valid = 1'b1;
      end else begin
        bus8.in_valid = 1'b0;
      end
      @(posedge ck); #1;
      if (i > 0) expect8("stream", chain[i-1], 4'b0000);
    end

    // Randomised traffic, checked by the compare process.
    for (int i = 0; i < 400; i++) begin
      bus8.in_valid = ($urandom_range(3) != 0);
      bus8.ctr      = 4'($urandom_range(15));
      bus8.a        = 8'($urandom);
      bus8.b        = 8'($urandom);
      bus8.sel_acc  = 1'($urandom_range(1));
      @(posedge ck); #1;
    end
    bus8.in_valid = 1'b0;
    repeat (12) @(posedge ck);
    #1;

    // W=16: set C via FFFF+1, then ADC FFFF+0 with C=1.
    bus16.ctr = 4'h0; bus16.a = 16'hFFFF; bus16.b = 16'h0001; bus16.in_valid = 1'b1;
    @(posedge ck); #1;
    bus16.ctr = 4'h2; bus16.a = 16'hFFFF; bus16.b = 16'h0000;
    @(posedge ck); #1;
    bus16.in_valid = 1'b0;
    @(posedge ck); #1;
    check("adc16 o", 64'(bus16.o), 64'h0000);
    check("adc16 flags", 64'(bus16.flags), 64'(4'b1001));
    check("adc16 ov", 64'(bus16.out_valid), 64'd1);
    ref_op(4'h2, 64'hFFFF, 64'h0000, 1'b1, 16, r16, f16);
    check("adc16 model o", 64'(bus16.o), r16);
    check("adc16 model flags", 64'(bus16.flags), 64'(f16));

    // Reset during a multiply aborts it.
    bus8.ctr = 4'hB; bus8.a = 8'h03; bus8.b = 8'h05; bus8.sel_acc = 1'b0; bus8.in_valid = 1'b1;
    @(posedge ck); #1;
    bus8.in_valid = 1'b0;
    @(posedge ck); #1;
    @(posedge ck); #1;
    check("pre-abort busy", 64'(bus8.in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("abort o", 64'(bus8.o), 64'd0);
    check("abort flags", 64'(bus8.flags), 64'd0);
    check("abort rdy", 64'(bus8.in_ready), 64'd1);
    check("abort ov", 64'(bus8.out_valid), 64'd0);
    @(negedge ck);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge ck); #1;
      check("abort no ov", 64'(bus8.out_valid), 64'd0);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
